sd_cmd_engine: RTL and testbench

//  Parametrised SD-host CMD-line engine; successor to the fixed-format SDHOST command path.

---
 rtl/sd_pkg.sv | 28 ++
 rtl/sd_crc7.sv | 27 ++
 rtl/sd_cmd_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-host CMD-line engine: FSM encoding, response types,
// frame geometry and the serial CRC7 step.
package sd_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RECV = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_R1   = 2'b01;
  localparam logic [1:0] RESP_R2   = 2'b10;
  localparam logic [1:0] RESP_R3   = 2'b11;

  localparam int unsigned CMD_FRAME_W  = 48;
  localparam int unsigned LONG_FRAME_W = 136;
  localparam logic [6:0]  CRC7_POLY    = 7'h09;

  // One bit of x^7+x^3+1, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr restarts from zero, en folds in one bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] r_crc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_crc <= 7'h00;
    end else if (clr) begin
      r_crc <= 7'h00;
    end else if (en) begin
      r_crc <= crc7_step(r_crc, din);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD-host CMD-line engine: serialises a 48-bit command with CRC7, then captures and checks
// a 48- or 136-bit response, all paced by the sd_clk_en bit tick.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_BITS = 64,
  parameter int unsigned NCC_BITS     = 8,
  parameter int unsigned RESP_W       = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sd_clk_en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_index,
  input  logic [31:0]       cmd_arg,
  input  logic [1:0]        resp_type,
  input  logic              cmd_pin_in,
  output logic              cmd_pin_out,
  output logic              cmd_oe,
  output logic              resp_valid,
  output logic [RESP_W-1:0] resp_data,
  output logic              err_timeout,
  output logic              err_crc,
  output logic              err_index,
  output logic              err_end,
  output logic              busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_BITS + 1);

  logic [2:0]        r_state;
  logic [7:0]        r_bit_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [5:0]        r_index;
  logic [1:0]        r_type;
  logic [39:0]       r_tx_shift;
  logic [126:0]      r_rx_shift;
  logic              r_pin_out;
  logic              r_oe;
  logic              r_resp_valid;
  logic [RESP_W-1:0] r_resp_data;
  logic              r_err_timeout;
  logic              r_err_crc;
  logic              r_err_index;
  logic              r_err_end;

  logic              w_accept;
  logic              w_long;
  logic [7:0]        w_last_idx;
  logic              w_start;
  logic [7:0]        w_rx_k;
  logic              w_rx_feed;
  logic              w_tx_crc_en;
  logic [6:0]        w_tx_crc;
  logic [6:0]        w_rx_crc;
  logic [2:0]        w_crc_idx;
  logic              w_tx_bit;
  logic [127:0]      w_frame;
  logic              w_err_crc;
  logic              w_err_index;
  logic [RESP_W-1:0] w_resp_next;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_long     = (r_type == RESP_R2);
  assign w_last_idx = w_long ? 8'(LONG_FRAME_W - 1) : 8'(CMD_FRAME_W - 1);
  assign w_start    = sd_clk_en && (r_state == ST_WAIT) && !cmd_pin_in &&
                      (r_to_cnt < TO_W'(TIMEOUT_BITS));

  // Received bit ordinal (start bit = 0); CRC covers frame[47:8] or frame[127:8].
  assign w_rx_k    = (r_state == ST_WAIT) ? 8'd0 : r_bit_cnt;
  assign w_rx_feed = (w_start || (sd_clk_en && (r_state == ST_RECV))) &&
                     (w_long ? ((w_rx_k >= 8'd8) && (w_rx_k < 8'd128)) : (w_rx_k < 8'd40));

  assign w_tx_crc_en = sd_clk_en && (r_state == ST_SEND) && (r_bit_cnt < 8'd40);

  always_comb begin
    w_crc_idx = 3'(8'd46 - r_bit_cnt);
    w_tx_bit  = 1'b1;
    if (r_bit_cnt < 8'd40) begin
      w_tx_bit = r_tx_shift[39];
    end else if (r_bit_cnt < 8'd47) begin
      w_tx_bit = w_tx_crc[w_crc_idx];
    end
  end

  assign w_frame     = {r_rx_shift, cmd_pin_in};
  assign w_err_crc   = (r_type != RESP_R3) && (w_frame[7:1] != w_rx_crc);
  assign w_err_index = (r_type == RESP_R1) && (w_frame[45:40] != r_index);
  assign w_resp_next = w_long ? RESP_W'(w_frame[127:0]) : RESP_W'(w_frame[39:8]);

  sd_crc7 u_tx_crc (
    .clock (clock),
    .reset (reset),
    .clr   (w_accept),
    .en    (w_tx_crc_en),
    .din   (r_tx_shift[39]),
    .crc   (w_tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clock (clock),
    .reset (reset),
    .clr   (w_accept),
    .en    (w_rx_feed),
    .din   (cmd_pin_in),
    .crc   (w_rx_crc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 8'd0;
      r_to_cnt      <= '0;
      r_index       <= 6'd0;
      r_type        <= RESP_NONE;
      r_tx_shift    <= 40'd0;
      r_rx_shift    <= '0;
      r_pin_out     <= 1'b1;
      r_oe          <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_err_timeout <= 1'b0;
      r_err_crc     <= 1'b0;
      r_err_index   <= 1'b0;
      r_err_end     <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_index       <= cmd_index;
            r_type        <= resp_type;
            r_tx_shift    <= {2'b01, cmd_index, cmd_arg};
            r_bit_cnt     <= 8'd0;
            r_err_timeout <= 1'b0;
            r_err_crc     <= 1'b0;
            r_err_index   <= 1'b0;
            r_err_end     <= 1'b0;
            r_state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (sd_clk_en) begin
            r_pin_out  <= w_tx_bit;
            r_oe       <= 1'b1;
            r_tx_shift <= {r_tx_shift[38:0], 1'b0};
            if (r_bit_cnt == 8'd47) begin
              r_bit_cnt <= 8'd0;
              r_to_cnt  <= '0;
              // No response expected: complete now and go straight to the NCC gap.
              if (r_type == RESP_NONE) begin
                r_resp_valid <= 1'b1;
                r_state      <= ST_GAP;
              end else begin
                r_state <= ST_WAIT;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        ST_WAIT: begin
          if (sd_clk_en) begin
            r_oe <= 1'b0;
            if (w_start) begin
              r_rx_shift <= {r_rx_shift[125:0], 1'b0};
              r_bit_cnt  <= 8'd1;
              r_state    <= ST_RECV;
            end else if (r_to_cnt == TO_W'(TIMEOUT_BITS - 1)) begin
              r_err_timeout <= 1'b1;
              r_resp_valid  <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (sd_clk_en) begin
            r_rx_shift <= {r_rx_shift[125:0], cmd_pin_in};
            if (r_bit_cnt == w_last_idx) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_resp_next;
              r_err_end    <= !cmd_pin_in;
              r_err_crc    <= w_err_crc;
              r_err_index  <= w_err_index;
              r_state      <= ST_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          r_bit_cnt <= 8'd0;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (sd_clk_en) begin
            r_oe <= 1'b0;
            if (r_bit_cnt == 8'(NCC_BITS - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = !cmd_ready;
  assign cmd_pin_out = r_pin_out;
  assign cmd_oe      = r_oe;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign err_timeout = r_err_timeout;
  assign err_crc     = r_err_crc;
  assign err_index   = r_err_index;
  assign err_end     = r_err_end;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: directed SD command cases plus randomized transactions, with a
// card model on cmd_pin_in and expectations from a polynomial-division CRC7 model.
module tb_sd_cmd_engine;

  localparam int unsigned TIMEOUT_BITS = 64;
  localparam int unsigned NCC_BITS     = 8;
  localparam int unsigned RESP_W       = 128;

  logic              clock = 1'b0;
  logic              reset;
  logic              sd_clk_en;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_arg;
  logic [1:0]        resp_type;
  logic              cmd_pin_in;
  logic              cmd_pin_out;
  logic              cmd_oe;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic              err_timeout;
  logic              err_crc;
  logic              err_index;
  logic              err_end;
  logic              busy;

  sd_cmd_engine #(
    .TIMEOUT_BITS (TIMEOUT_BITS),
    .NCC_BITS     (NCC_BITS),
    .RESP_W       (RESP_W)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .sd_clk_en   (sd_clk_en),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .resp_type   (resp_type),
    .cmd_pin_in  (cmd_pin_in),
    .cmd_pin_out (cmd_pin_out),
    .cmd_oe      (cmd_oe),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .err_timeout (err_timeout),
    .err_crc     (err_crc),
    .err_index   (err_index),
    .err_end     (err_end),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int           tick_period = 1;
  int           div = 0;
  bit           noise = 0;
  logic         busy_last = 1'b0;
  bit           card_on = 0;
  logic [135:0] card_frame;
  int           card_len;
  int           card_delay;
  int           post_ticks;
  logic [47:0]  tx_bits;
  int           tx_n;
  int           rv_count;
  int           rv_post;
  logic         oe_after_end;
  logic [3:0]   cap_err;
  logic [127:0] cap_data;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89).
  function automatic logic [6:0] crc7_ref(input logic [135:0] bits, input int len);
    logic [7:0] rem;
    logic       b;
    rem = 8'h00;
    for (int i = 0; i < len + 7; i++) begin
      b   = (i < len) ? bits[len-1-i] : 1'b0;
      rem = {rem[6:0], b};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(136'(m), 40), 1'b1};
  endfunction

  function automatic logic [47:0] short_resp(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b00, idx, arg};
    return {m, crc7_ref(136'(m), 40), 1'b1};
  endfunction

  function automatic logic [135:0] long_resp(input logic [119:0] p);
    return {2'b00, 6'h3F, p, crc7_ref(136'(p), 120), 1'b1};
  endfunction

  // One system clock: drive tick/card/noise at negedge, observe #1 after posedge.
  task automatic cycle();
    logic t;
    int   k;
    @(negedge clock);
    t         = (div == 0);
    div       = (div + 1) % tick_period;
    sd_clk_en = t;
    k         = post_ticks - card_delay;
    if (card_on && post_ticks >= 0 && k >= 0 && k < card_len) cmd_pin_in = card_frame[card_len-1-k];
    else cmd_pin_in = 1'b1;
    if (noise && busy_last && $urandom_range(3) == 0) begin
      cmd_valid = 1'b1;
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      resp_type = 2'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    busy_last = busy;
    if (t) begin
      if (post_ticks >= 0) post_ticks++;
      if (cmd_oe && tx_n < 48) begin
        tx_bits = {tx_bits[46:0], cmd_pin_out};
        tx_n++;
        if (tx_n == 48) post_ticks = 0;
      end
      if (post_ticks == 1) oe_after_end = cmd_oe;
    end
    if (resp_valid) begin
      rv_count++;
      rv_post  = post_ticks;
      cap_err  = {err_timeout, err_crc, err_index, err_end};
      cap_data = resp_data;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input int period, input bit respond,
                         input logic [135:0] frame, input int delay, input int abort_at);
    int           len;
    bit           done;
    logic         e_to, e_crc, e_idx, e_end;
    logic [127:0] exp_data;
    len          = (typ == 2'b10) ? 136 : 48;
    tick_period  = period;
    div          = 0;
    card_frame   = frame;
    card_len     = len;
    card_delay   = delay;
    card_on      = respond && (typ != 2'b00);
    tx_n         = 0;
    tx_bits      = '0;
    post_ticks   = -1;
    rv_count     = 0;
    rv_post      = -1;
    oe_after_end = 1'bx;
    cap_err      = 'x;
    cap_data     = 'x;
    @(negedge clock);
    sd_clk_en  = 1'b0;
    cmd_pin_in = 1'b1;
    cmd_valid  = 1'b1;
    cmd_index  = idx;
    cmd_arg    = arg;
    resp_type  = typ;
    @(posedge clock);
    #1;
    busy_last = busy;
    check({tag, "_accept_busy"}, busy, 1'b1);
    done = 0;
    for (int c = 0; c < 6000 && !done; c++) begin
      cycle();
      if (abort_at >= 0 && tx_n == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check({tag, "_rst_lines"}, {cmd_oe, cmd_pin_out, cmd_ready, busy, resp_valid}, 5'b01100);
        check({tag, "_rst_data"}, {resp_data, err_timeout, err_crc, err_index, err_end}, '0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset     = 1'b1;
        sd_clk_en = 1'b0;
        check({tag, "_no_partial_valid"}, rv_count, 0);
        return;
      end
      if (cmd_ready) done = 1;
    end
    cmd_valid = 1'b0;
    check({tag, "_completes"}, done, 1'b1);
    check({tag, "_tx_frame"}, tx_bits, cmd_frame(idx, arg));
    check({tag, "_oe_drop"}, oe_after_end, 1'b0);
    check({tag, "_one_valid"}, rv_count, 1);
    {e_to, e_crc, e_idx, e_end} = 4'b0000;
    if (typ != 2'b00) begin
      if (!respond || delay >= int'(TIMEOUT_BITS)) begin
        e_to = 1'b1;
        check({tag, "_timeout_ticks"}, rv_post, TIMEOUT_BITS);
      end else begin
        e_end = !frame[0];
        if (typ == 2'b01) e_crc = (crc7_ref(136'(frame[47:8]), 40) != frame[7:1]);
        if (typ == 2'b10) e_crc = (crc7_ref(136'(frame[127:8]), 120) != frame[7:1]);
        e_idx    = (typ == 2'b01) && (frame[45:40] != idx);
        exp_data = (typ == 2'b10) ? frame[127:0] : 128'(frame[39:8]);
        check({tag, "_resp_data"}, cap_data, exp_data);
      end
    end
    check({tag, "_errors"}, cap_err, {e_to, e_crc, e_idx, e_end});
    check({tag, "_errors_held"}, {err_timeout, err_crc, err_index, err_end},
          {e_to, e_crc, e_idx, e_end});
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got no end of test, expected finish before 900us");
    $fatal(1);
  end

  initial begin
    logic [135:0] fr;
    logic [127:0] rnd;
    logic [1:0]   typ;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           kind;
    int           dly;
    bit           rsp;

    reset      = 1'b0;
    sd_clk_en  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_index  = 6'd0;
    cmd_arg    = 32'd0;
    resp_type  = 2'b00;
    cmd_pin_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_lines", {cmd_ready, cmd_pin_out, cmd_oe, resp_valid, busy}, 5'b11000);
    check("reset_data", {resp_data, err_timeout, err_crc, err_index, err_end}, '0);
    @(negedge clock);
    reset = 1'b1;

    run_cmd("cmd0", 6'd0, 32'd0, 2'b00, 1, 0, '0, 0, -1);
    check("cmd0_tx_bytes", tx_bits, 48'h40_0000_0000_95);

    run_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, 1, 1, 136'(48'h08_0000_01AA_13), 5, -1);
    check("cmd8_tx_bytes", tx_bits, 48'h48_0000_01AA_87);
    check("cmd8_resp_const", cap_data, 128'h1AA);

    noise = 1;
    run_cmd("cmd8_slow", 6'd8, 32'h1AA, 2'b01, 4, 1, 136'(48'h08_0000_01AA_13), 5, -1);
    check("cmd8_slow_tx_bytes", tx_bits, 48'h48_0000_01AA_87);
    check("cmd8_slow_resp_const", cap_data, 128'h1AA);
    noise = 0;

    run_cmd("r1_silent", 6'd17, 32'h1234_5678, 2'b01, 1, 0, '0, 0, -1);
    check("r1_silent_flags", cap_err, 4'b1000);
    run_cmd("r1_badcrc", 6'd8, 32'h1AA, 2'b01, 2, 1, 136'(48'h08_0000_01AA_13 ^ 48'h4), 3, -1);
    check("r1_badcrc_flags", cap_err, 4'b0100);
    run_cmd("r1_badidx", 6'd8, 32'h1AA, 2'b01, 1, 1, 136'(short_resp(6'd9, 32'h1AA)), 2, -1);
    check("r1_badidx_flags", cap_err, 4'b0010);
    run_cmd("r1_badend", 6'd55, 32'hCAFE_0001, 2'b01, 1, 1,
            136'(short_resp(6'd55, 32'h0900) ^ 48'h1), 0, -1);
    run_cmd("r1_last_ok", 6'd13, 32'h0, 2'b01, 1, 1, 136'(short_resp(6'd13, 32'h900)),
            TIMEOUT_BITS - 1, -1);
    run_cmd("r1_too_late", 6'd13, 32'h0, 2'b01, 1, 1, 136'(short_resp(6'd13, 32'h900)),
            TIMEOUT_BITS, -1);

    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_cmd("r2_cid", 6'd2, 32'd0, 2'b10, 1, 1, long_resp(rnd[119:0]), 4, -1);
    check("r2_cid_flags", cap_err, 4'b0000);
    run_cmd("r3_badcrc", 6'd41, 32'h40FF_8000, 2'b11, 1, 1,
            136'(short_resp(6'h3F, 32'h80FF_8000) ^ 48'h2), 1, -1);
    check("r3_badcrc_flags", cap_err, 4'b0000);

    run_cmd("abort", 6'd0, 32'd0, 2'b00, 1, 0, '0, 0, 20);
    run_cmd("cmd0_after_rst", 6'd0, 32'd0, 2'b00, 1, 0, '0, 0, -1);
    check("cmd0_after_rst_bytes", tx_bits, 48'h40_0000_0000_95);

    noise = 1;
    for (int n = 0; n < 16; n++) begin
      typ  = 2'($urandom);
      idx  = 6'($urandom);
      arg  = $urandom;
      kind = $urandom_range(0, 5);
      dly  = $urandom_range(0, 20);
      rsp  = 1;
      if (typ == 2'b10) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        fr  = long_resp(rnd[119:0]);
      end else begin
        fr = 136'(short_resp((kind == 2) ? (idx ^ 6'(1 + $urandom_range(0, 62))) : idx, $urandom));
      end
      if (kind == 1) fr = fr ^ (136'd1 << $urandom_range(1, 7));
      if (kind == 3) fr[0] = 1'b0;
      if (kind == 4) rsp = 0;
      if (kind == 5) dly = TIMEOUT_BITS - 1;
      run_cmd($sformatf("rand%0d", n), idx, arg, typ, $urandom_range(1, 3), rsp, fr, dly, -1);
    end
    noise = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
